// File: rtl/shr_pkg.sv
// Shared definitions for the shr_* serial shifter family:
// bit-order encoding, FSM state encoding and the counter-width helper.
package shr_pkg;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shr_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/shr_hold1.sv
// Single-entry word buffer with a full flag: accepts when empty, empties on pop.
// Pop only happens while full and accept only while empty, so the two never coincide.
module shr_hold1 import shr_pkg::*; #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;
  logic         w_accept;

  assign w_accept = i_push && !r_full && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 1'b0;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_full <= 1'b1;
    end
  end

  // NOTE: the payload is deliberately not reset; r_full alone says whether it is meaningful.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/shr_npiso.sv
// Parallel-in serial-out shifter with a valid/ready word input, a one-word
// holding buffer for gapless back-to-back words, and valid/last bit framing.
module shr_npiso import shr_pkg::*; #(
  parameter int   W         = 6,
  parameter int   MSB_FIRST = 0,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_din,
  input  logic         i_din_valid,
  output logic         o_ready,
  output logic         o_dout,
  output logic         o_dout_valid,
  output logic         o_last
);

  localparam int            CW      = cnt_w(W);
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  shr_state_e    r_state;
  shr_state_e    w_state_nxt;
  logic [W-1:0]  r_sr;
  logic [W-1:0]  w_sr_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_dout;
  logic          w_dout_nxt;
  logic          r_dout_valid;
  logic          w_dout_valid_nxt;

  logic          w_hold_full;
  logic [W-1:0]  w_hold_data;
  logic          w_cnt_zero;
  logic          w_load;
  logic          w_load_bit;
  logic [W-1:0]  w_load_sr;
  logic          w_next_bit;
  logic [W-1:0]  w_shift_sr;

  shr_hold1 #(.W(W)) u_hold (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (i_din_valid),
    .i_data (i_din),
    .i_pop  (w_load),
    .o_full (w_hold_full),
    .o_data (w_hold_data)
  );

  // Bit order is fixed at elaboration: the first bit goes straight to DOUT,
  // the rest sit in SR with the next bit always at the shifting end.
  if (MSB_FIRST == shr_pkg::MSB_FIRST) begin : g_msb_first
    assign w_load_bit = w_hold_data[W-1];
    assign w_load_sr  = {w_hold_data[W-2:0], 1'b0};
    assign w_next_bit = r_sr[W-1];
    assign w_shift_sr = {r_sr[W-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_load_bit = w_hold_data[0];
    assign w_load_sr  = {1'b0, w_hold_data[W-1:1]};
    assign w_next_bit = r_sr[0];
    assign w_shift_sr = {1'b0, r_sr[W-1:1]};
  end

  assign w_cnt_zero = (r_cnt == '0);
  // A held word moves into the shifter on a tick when the line is idle or the last bit just completed.
  assign w_load     = i_en && w_hold_full && ((r_state == ST_IDLE) || w_cnt_zero);

  // NOTE: every next-value defaults to its current value first, so no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_sr_nxt         = r_sr;
    w_cnt_nxt        = r_cnt;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = r_dout_valid;
    if (w_load) begin
      w_state_nxt      = ST_SHIFT;
      w_dout_nxt       = w_load_bit;
      w_sr_nxt         = w_load_sr;
      w_cnt_nxt        = CNT_TOP;
      w_dout_valid_nxt = 1'b1;
    end else if (i_en && (r_state == ST_SHIFT)) begin
      if (!w_cnt_zero) begin
        w_dout_nxt = w_next_bit;
        w_sr_nxt   = w_shift_sr;
        w_cnt_nxt  = r_cnt - 1'b1;
      end else begin
        w_state_nxt      = ST_IDLE;
        w_dout_nxt       = IDLE_LVL;
        w_dout_valid_nxt = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_dout       <= IDLE_LVL;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sr         <= w_sr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  assign o_ready      = !w_hold_full;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_last       = r_dout_valid && w_cnt_zero;

endmodule

// File: tb/tb_shr_npiso.sv
// Directed bench for shr_npiso: three instances cover LSB/MSB order, W=6/8
// and both idle levels; expected bit streams are hand-derived constants.
module tb_shr_npiso;

  logic       clk;
  logic       rst;
  logic       en;
  logic [5:0] din_a;
  logic       valid_a;
  logic       ready_a, dout_a, dv_a, last_a;
  logic [7:0] din_b;
  logic       valid_b;
  logic       ready_b, dout_b, dv_b, last_b;
  logic [5:0] din_c;
  logic       valid_c;
  logic       ready_c, dout_c, dv_c, last_c;

  int n_assert = 0;
  int n_fail   = 0;

  shr_npiso #(.W(6), .MSB_FIRST(0), .IDLE_LVL(1'b0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din_a), .i_din_valid(valid_a),
    .o_ready(ready_a), .o_dout(dout_a), .o_dout_valid(dv_a), .o_last(last_a)
  );

  shr_npiso #(.W(8), .MSB_FIRST(1), .IDLE_LVL(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din_b), .i_din_valid(valid_b),
    .o_ready(ready_b), .o_dout(dout_b), .o_dout_valid(dv_b), .o_last(last_b)
  );

  shr_npiso #(.W(6), .MSB_FIRST(0), .IDLE_LVL(1'b1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din_c), .i_din_valid(valid_c),
    .o_ready(ready_c), .o_dout(dout_c), .o_dout_valid(dv_c), .o_last(last_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; before it, confirm accept and transfer are never requested together.
  task automatic tick();
    check("a_no_accept_with_load", {31'd0, u_a.u_hold.w_accept && u_a.w_load}, 32'd0);
    check("b_no_accept_with_load", {31'd0, u_b.u_hold.w_accept && u_b.w_load}, 32'd0);
    check("c_no_accept_with_load", {31'd0, u_c.u_hold.w_accept && u_c.w_load}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  exp6;
  logic [15:0] exp16;
  logic [11:0] exp12;

  initial begin
    rst = 1'b1; en = 1'b0;
    din_a = '0; valid_a = 1'b0;
    din_b = '0; valid_b = 1'b0;
    din_c = '0; valid_c = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state on all instances
    check("a_rst_ready", {31'd0, ready_a}, 32'd1);
    check("a_rst_dout",  {31'd0, dout_a},  32'd0);
    check("a_rst_dv",    {31'd0, dv_a},    32'd0);
    check("a_rst_last",  {31'd0, last_a},  32'd0);
    check("b_rst_ready", {31'd0, ready_b}, 32'd1);
    check("b_rst_dout",  {31'd0, dout_b},  32'd0);
    check("c_rst_ready", {31'd0, ready_c}, 32'd1);
    check("c_rst_dout",  {31'd0, dout_c},  32'd1);
    check("c_rst_dv",    {31'd0, dv_c},    32'd0);

    // W=6 LSB-first single word 101101, EN always high
    en = 1'b1;
    din_a = 6'b101101; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    check("a_s1_ready_after_accept", {31'd0, ready_a}, 32'd0);
    check("a_s1_dv_before_first",    {31'd0, dv_a},    32'd0);
    exp6 = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("a_s1_bit%0d", i),  {31'd0, dout_a}, {31'd0, exp6[i]});
      check($sformatf("a_s1_dv%0d", i),   {31'd0, dv_a},   32'd1);
      check($sformatf("a_s1_last%0d", i), {31'd0, last_a}, (i == 5) ? 32'd1 : 32'd0);
    end
    tick();
    check("a_s1_dv_end",   {31'd0, dv_a},   32'd0);
    check("a_s1_dout_end", {31'd0, dout_a}, 32'd0);
    check("a_s1_last_end", {31'd0, last_a}, 32'd0);

    // W=8 MSB-first back-to-back A5 then 3C, DIN_VALID held
    din_b = 8'hA5; valid_b = 1'b1;
    tick();
    din_b = 8'h3C;
    check("b_s2_ready_after_accept", {31'd0, ready_b}, 32'd0);
    exp16 = 16'hA53C;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 1) valid_b = 1'b0;
      check($sformatf("b_s2_bit%0d", i),  {31'd0, dout_b}, {31'd0, exp16[15-i]});
      check($sformatf("b_s2_dv%0d", i),   {31'd0, dv_b},   32'd1);
      check($sformatf("b_s2_last%0d", i), {31'd0, last_b}, (i == 7 || i == 15) ? 32'd1 : 32'd0);
      if (i == 0) check("b_s2_ready_pulse", {31'd0, ready_b}, 32'd1);
      if (i == 1) check("b_s2_ready_held",  {31'd0, ready_b}, 32'd0);
      if (i == 9) check("b_s2_ready_free",  {31'd0, ready_b}, 32'd1);
    end
    tick();
    check("b_s2_dv_end", {31'd0, dv_b}, 32'd0);

    // W=6 LSB-first, EN one cycle in three, 2A then 15 accepted mid-word
    en = 1'b0;
    din_a = 6'h2A; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    exp12 = {6'h15, 6'h2A};
    for (int c = 0; c < 36; c++) begin
      en = (c % 3 == 0);
      valid_a = (c == 4);
      din_a = (c == 4) ? 6'h15 : 6'h2A;
      tick();
      check($sformatf("a_s3_bit_c%0d", c),   {31'd0, dout_a},  {31'd0, exp12[c/3]});
      check($sformatf("a_s3_dv_c%0d", c),    {31'd0, dv_a},    32'd1);
      check($sformatf("a_s3_last_c%0d", c),  {31'd0, last_a},  ((c / 3) % 6 == 5) ? 32'd1 : 32'd0);
      check($sformatf("a_s3_ready_c%0d", c), {31'd0, ready_a}, (c >= 4 && c < 18) ? 32'd0 : 32'd1);
    end
    valid_a = 1'b0;
    en = 1'b1;
    tick();
    check("a_s3_dv_end",   {31'd0, dv_a},   32'd0);
    check("a_s3_dout_end", {31'd0, dout_a}, 32'd0);

    // DIN_VALID while READY=0: 11 must be ignored, 2E accepted next
    din_a = 6'h03; valid_a = 1'b1;
    tick();
    check("a_s6_ready_after_accept", {31'd0, ready_a}, 32'd0);
    exp12 = {6'h2E, 6'h03};
    for (int i = 0; i < 12; i++) begin
      if (i == 0) din_a = 6'h11;
      if (i == 1) din_a = 6'h2E;
      if (i == 2) valid_a = 1'b0;
      tick();
      check($sformatf("a_s6_bit%0d", i),  {31'd0, dout_a}, {31'd0, exp12[i]});
      check($sformatf("a_s6_dv%0d", i),   {31'd0, dv_a},   32'd1);
      check($sformatf("a_s6_last%0d", i), {31'd0, last_a}, (i == 5 || i == 11) ? 32'd1 : 32'd0);
      if (i == 0) check("a_s6_ready_after_pop",    {31'd0, ready_a}, 32'd1);
      if (i == 1) check("a_s6_ready_after_accept2", {31'd0, ready_a}, 32'd0);
    end
    tick();
    check("a_s6_dv_end", {31'd0, dv_a}, 32'd0);

    // IDLE_LVL=1: reset mid-word with a word held; nothing emitted afterwards
    din_c = 6'h07; valid_c = 1'b1;
    tick();
    din_c = 6'h38;
    tick();
    check("c_s5_bit0", {31'd0, dout_c}, 32'd1);
    tick();
    valid_c = 1'b0;
    tick();
    check("c_s5_bit2",       {31'd0, dout_c},  32'd1);
    check("c_s5_dv_mid",     {31'd0, dv_c},    32'd1);
    check("c_s5_ready_held", {31'd0, ready_c}, 32'd0);
    rst = 1'b1; din_c = 6'h3F; valid_c = 1'b1;
    tick();
    rst = 1'b0; valid_c = 1'b0;
    check("c_s5_rst_dout",  {31'd0, dout_c},  32'd1);
    check("c_s5_rst_dv",    {31'd0, dv_c},    32'd0);
    check("c_s5_rst_last",  {31'd0, last_c},  32'd0);
    check("c_s5_rst_ready", {31'd0, ready_c}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("c_s5_post_dv%0d", i),    {31'd0, dv_c},    32'd0);
      check($sformatf("c_s5_post_dout%0d", i),  {31'd0, dout_c},  32'd1);
      check($sformatf("c_s5_post_ready%0d", i), {31'd0, ready_c}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
